// File: rtl/uart_tx_engine.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB-first, optional
// parity, 1 or 2 stop bits. tx_busy spans the whole frame; tx_done pulses once at the end.
module uart_tx_engine #(
  parameter int CLK_FREQ  = 100,
  parameter int BAUD_RATE = 10,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_serial
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int BW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] CPB_M1  = BW'(CPB - 1);
  localparam logic [2:0]    STOP_M1 = 3'(STOP_BITS - 1);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_engine: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_engine: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_engine: STOP_BITS must be 1 or 2");
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          serial_q, serial_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_tick;

  assign baud_tick = (baud_q == CPB_M1);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (state_q != ST_IDLE) begin
      baud_d = baud_tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          shift_d  = tx_data;
          par_d    = (PARITY == 2) ? ~^tx_data : ^tx_data;
          serial_d = 1'b0;
          busy_d   = 1'b1;
          baud_d   = '0;
          bit_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick) begin
          serial_d = shift_q[0];
          bit_d    = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY != 0) begin
              serial_d = par_q;
              state_d  = ST_PAR;
            end else begin
              serial_d = 1'b1;
              state_d  = ST_STOP;
            end
          end else begin
            // shift_q[0] is already on the line; present the next bit
            serial_d = shift_q[1];
            shift_d  = {1'b0, shift_q[7:1]};
            bit_d    = bit_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (baud_tick) begin
          serial_d = 1'b1;
          bit_d    = '0;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (bit_q == STOP_M1) begin
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        baud_d   = '0;
        bit_d    = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: per-cycle line values are queued when a
// frame is launched and compared as the frame is shifted out.
module tb_uart_tx_engine;

  localparam int CPB = 10;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       start_v [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       ser_v   [3];

  int checks;
  int errors;
  logic exp_q [$];

  // 0: 8N1, 1: even parity + 2 stop, 2: odd parity + 2 stop
  uart_tx_engine dut_n (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(start_v[0]),
    .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx_serial(ser_v[0]));

  uart_tx_engine #(.PARITY(1), .STOP_BITS(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(start_v[1]),
    .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx_serial(ser_v[1]));

  uart_tx_engine #(.PARITY(2), .STOP_BITS(2)) dut_o (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(start_v[2]),
    .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx_serial(ser_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    logic bad;
    bad = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++)
        if (ser_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) bad = 1'b1;
    end
    check(tag, {31'd0, bad}, 32'd0);
  endtask

  // Caller is just past a falling edge. When do_start is 0 the start was already
  // driven by the previous frame's done cycle. Returns in the done cycle.
  task automatic run_frame(input int sel, input logic [7:0] data, input int par,
                           input int sb, input bit do_start, input int ign_at,
                           input bit chain, input logic [7:0] next_data);
    int   nbits;
    int   busy_cnt;
    logic line_bad;
    logic done_early;
    logic exp_bit;
    logic [7:0] d;
    d = data;
    nbits = 9 + ((par != 0) ? 1 : 0) + sb;
    for (int c = 0; c < CPB; c++) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(d[b]);
    if (par != 0)
      for (int c = 0; c < CPB; c++) exp_q.push_back((par == 2) ? ~^d : ^d);
    for (int c = 0; c < sb * CPB; c++) exp_q.push_back(1'b1);

    if (do_start) begin
      tx_data = data;
      start_v[sel] = 1'b1;
    end
    @(negedge clk);
    start_v[sel] = 1'b0;
    tx_data = ~data;

    busy_cnt = 0;
    line_bad = 1'b0;
    done_early = 1'b0;
    for (int c = 1; c <= nbits * CPB; c++) begin
      exp_bit = exp_q.pop_front();
      if (ser_v[sel] !== exp_bit) begin
        if (!line_bad)
          $display("line diverges at frame cycle %0d: observed=%b expected=%b", c, ser_v[sel], exp_bit);
        line_bad = 1'b1;
      end
      if (busy_v[sel] === 1'b1) busy_cnt++;
      if (done_v[sel] !== 1'b0) done_early = 1'b1;
      if (ign_at != 0 && c == ign_at) begin
        tx_data = 8'hFF;
        start_v[sel] = 1'b1;
      end else if (ign_at != 0 && c == ign_at + 1) begin
        start_v[sel] = 1'b0;
      end
      @(negedge clk);
    end
    check($sformatf("line_%0d_%02h", sel, data), {31'd0, line_bad}, 32'd0);
    check($sformatf("busy_len_%0d_%02h", sel, data), busy_cnt, nbits * CPB);
    check($sformatf("no_early_done_%0d_%02h", sel, data), {31'd0, done_early}, 32'd0);
    check($sformatf("done_pulse_%0d_%02h", sel, data), {31'd0, done_v[sel]}, 32'd1);
    check($sformatf("busy_low_at_done_%0d_%02h", sel, data), {31'd0, busy_v[sel]}, 32'd0);
    check($sformatf("line_idle_at_done_%0d_%02h", sel, data), {31'd0, ser_v[sel]}, 32'd1);
    if (chain) begin
      tx_data = next_data;
      start_v[sel] = 1'b1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    tx_data = 8'h00;
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_serial_%0d", d), {31'd0, ser_v[d]}, 32'd1);
      check($sformatf("rst_busy_%0d", d), {31'd0, busy_v[d]}, 32'd0);
      check($sformatf("rst_done_%0d", d), {31'd0, done_v[d]}, 32'd0);
    end
    idle_cycles(200, "quiet_after_reset");

    // Single 8N1 frame
    run_frame(0, 8'hA5, 0, 1, 1'b1, 0, 1'b0, 8'h00);
    @(negedge clk);
    check("done_single_cycle", {31'd0, done_v[0]}, 32'd0);
    idle_cycles(10, "idle_after_a5");

    // Start request during a frame is dropped
    run_frame(0, 8'h3C, 0, 1, 1'b1, 40, 1'b0, 8'h00);
    idle_cycles(40, "no_second_frame");

    // Back-to-back: new start accepted in the done cycle
    run_frame(0, 8'h01, 0, 1, 1'b1, 0, 1'b1, 8'h80);
    run_frame(0, 8'h80, 0, 1, 1'b0, 0, 1'b0, 8'h00);
    idle_cycles(10, "idle_after_b2b");

    // Parity and two stop bits
    run_frame(1, 8'h07, 1, 2, 1'b1, 0, 1'b0, 8'h00);
    idle_cycles(5, "idle_after_even");
    run_frame(2, 8'h07, 2, 2, 1'b1, 0, 1'b0, 8'h00);
    idle_cycles(5, "idle_after_odd");
    run_frame(1, 8'hC3, 1, 2, 1'b1, 0, 1'b0, 8'h00);
    idle_cycles(5, "idle_after_even_c3");
    run_frame(2, 8'hC3, 2, 2, 1'b1, 0, 1'b0, 8'h00);
    idle_cycles(5, "idle_after_odd_c3");

    // Reset in the middle of a 0x00 frame
    tx_data = 8'h00;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (34) @(negedge clk);
    check("mid_frame_busy", {31'd0, busy_v[0]}, 32'd1);
    check("mid_frame_line", {31'd0, ser_v[0]}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort_serial", {31'd0, ser_v[0]}, 32'd1);
    check("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    check("abort_done", {31'd0, done_v[0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(150, "no_done_after_abort");

    run_frame(0, 8'h55, 0, 1, 1'b1, 0, 1'b0, 8'h00);
    idle_cycles(10, "idle_after_55");

    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
